alu_share_arbiter: RTL and testbench

Shares one instance of the existing combinational ALU (OP1/OP2/ALUCtl -> Res/ZF) between two requesters, for example the execute stage and a branch/address-compare unit. Each requester uses a valid/ready request channel. A round-robin arbiter selects one request per cycle, drives the ALU and captures Res/ZF into a one-entry output register. Results leave on a single response channel, tagged with the requester id and subject to backpressure.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu.sv | 28 ++
 rtl/alu_share_arbiter_rr_arb2.sv | 28 ++
 rtl/alu_share_arbiter.sv | 95 +++++++++
 tb/tb_alu_share_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the shared-ALU arbiter slice.
// The optional control-code check is enabled by defining ALU_SHARE_CTL_CHECK_EN.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    localparam logic [2:0] CTL_AND = 3'b000;
    localparam logic [2:0] CTL_OR  = 3'b001;
    localparam logic [2:0] CTL_ADD = 3'b010;
    localparam logic [2:0] CTL_SUB = 3'b110;
    localparam logic [2:0] CTL_SLT = 3'b111;

    typedef logic req_id_t;

    // Output register states.
    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    function automatic logic ctl_illegal(input logic [2:0] ctl);
        return (ctl == 3'b011) || (ctl == 3'b100) || (ctl == 3'b101);
    endfunction

endpackage

// File: rtl/alu.sv
// Existing combinational ALU: AND/OR/ADD/SUB/SLT selected by ALUCtl, ZF flags a zero result.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic [2:0]       ALUCtl,
    input  logic [WIDTH-1:0] OP1,
    input  logic [WIDTH-1:0] OP2,
    output logic [WIDTH-1:0] Res,
    output logic             ZF
);

    always_comb begin
        Res = '0;
        case (ALUCtl)
            CTL_AND: Res = OP1 & OP2;
            CTL_OR:  Res = OP1 | OP2;
            CTL_ADD: Res = OP1 + OP2;
            CTL_SUB: Res = OP1 - OP2;
            CTL_SLT: Res = {{(WIDTH-1){1'b0}}, ($signed(OP1) < $signed(OP2))};
            default: Res = '0;
        endcase
    end

    assign ZF = (Res == '0);

endmodule

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-input round-robin picker; the favour pointer moves past the winner only on an accept.
module rr_arb2
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant,
    output req_id_t    winner
);

    // favour = requester that wins when both are valid
    req_id_t favour;

    assign grant[0] = valid[0] & (~valid[1] | (favour == 1'b0));
    assign grant[1] = valid[1] & (~valid[0] | (favour == 1'b1));
    assign winner   = grant[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            favour <= 1'b0;
        end else if (accept) begin
            favour <= ~winner;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two valid/ready requesters with a one-entry tagged result register.
// Define ALU_SHARE_CTL_CHECK_EN to flag control codes 011/100/101 via rsp_err.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_op1,
    input  logic [WIDTH-1:0] req0_op2,
    input  logic [2:0]       req0_ctl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_op1,
    input  logic [WIDTH-1:0] req1_op2,
    input  logic [2:0]       req1_ctl,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_res,
    output logic             rsp_zf,
    output logic             rsp_err
);

    logic             state;
    logic             can_accept;
    logic             accept;
    logic [1:0]       grant;
    req_id_t          winner;
    logic [WIDTH-1:0] sel_op1;
    logic [WIDTH-1:0] sel_op2;
    logic [2:0]       sel_ctl;
    logic [2:0]       alu_ctl;
    logic [WIDTH-1:0] alu_res;
    logic             alu_zf;
    logic             illegal;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  ({req1_valid, req0_valid}),
        .accept (accept),
        .grant  (grant),
        .winner (winner)
    );

    // rst_n gates readiness so nothing is offered while reset is held
    assign can_accept = rst_n & ((state == ST_EMPTY) | rsp_ready);
    assign accept     = can_accept & (|grant);
    assign req0_ready = can_accept & grant[0];
    assign req1_ready = can_accept & grant[1];
    assign rsp_valid  = (state == ST_FULL);

    assign sel_op1 = winner ? req1_op1 : req0_op1;
    assign sel_op2 = winner ? req1_op2 : req0_op2;
    assign sel_ctl = winner ? req1_ctl : req0_ctl;

`ifdef ALU_SHARE_CTL_CHECK_EN
    assign illegal = ctl_illegal(sel_ctl);
    assign alu_ctl = illegal ? CTL_AND : sel_ctl;
`else
    assign illegal = 1'b0;
    assign alu_ctl = sel_ctl;
`endif

    alu #(.WIDTH(WIDTH)) u_alu (
        .ALUCtl (alu_ctl),
        .OP1    (sel_op1),
        .OP2    (sel_op2),
        .Res    (alu_res),
        .ZF     (alu_zf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_EMPTY;
            rsp_id  <= 1'b0;
            rsp_res <= '0;
            rsp_zf  <= 1'b0;
            rsp_err <= 1'b0;
        end else if (accept) begin
            state   <= ST_FULL;
            rsp_id  <= winner;
            rsp_res <= illegal ? '0 : alu_res;
            rsp_zf  <= illegal ? 1'b0 : alu_zf;
            rsp_err <= illegal;
        end else if (rsp_ready) begin
            state <= ST_EMPTY;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed bench for alu_share_arbiter against a transaction-level reference model.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic        v0, v1, r0, r1;
    logic [31:0] a0, b0, a1, b1;
    logic [2:0]  c0, c1;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zf, rsp_err;
    logic [31:0] rsp_res;

    int unsigned checks = 0;
    int unsigned failures = 0;

    // reference model: held response, next favoured requester
    logic        m_full, m_id, m_zf, m_err, m_fav;
    logic [31:0] m_res;
    logic        acc0, acc1, dut_r0, dut_r1;

    alu_share_arbiter #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (v0),
        .req0_ready (r0),
        .req0_op1   (a0),
        .req0_op2   (b0),
        .req0_ctl   (c0),
        .req1_valid (v1),
        .req1_ready (r1),
        .req1_op1   (a1),
        .req1_op2   (b1),
        .req1_ctl   (c1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_res    (rsp_res),
        .rsp_zf     (rsp_zf),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic ref_alu(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic zf, output logic err);
        err = 1'b0;
        case (ctl)
            3'd0: res = a & b;
            3'd1: res = a | b;
            3'd2: res = a + b;
            3'd6: res = a - b;
            3'd7: res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: begin
                res = 32'd0;
`ifdef ALU_SHARE_CTL_CHECK_EN
                err = 1'b1;
`endif
            end
        endcase
        zf = (res == 32'd0) && !err;
    endtask

    task automatic model_reset();
        m_full = 0; m_id = 0; m_zf = 0; m_err = 0; m_fav = 0; m_res = '0;
        acc0 = 0; acc1 = 0;
    endtask

    // One clock: check at negedge, update model at posedge, return 1 time unit later.
    task automatic step();
        logic can, g0, g1;
        @(negedge clk);
        can = !m_full || rsp_ready;
        g0 = v0 && (!v1 || m_fav == 1'b0);
        g1 = v1 && (!v0 || m_fav == 1'b1);
        acc0 = can && g0;
        acc1 = can && g1;
        dut_r0 = r0;
        dut_r1 = r1;
        check("req0_ready", r0, acc0);
        check("req1_ready", r1, acc1);
        check("rsp_valid", rsp_valid, m_full);
        if (m_full) begin
            check("rsp_res", rsp_res, m_res);
            check("rsp_zf", rsp_zf, m_zf);
            check("rsp_id", rsp_id, m_id);
            check("rsp_err", rsp_err, m_err);
        end
        @(posedge clk);
        if (acc0) ref_alu(c0, a0, b0, m_res, m_zf, m_err);
        if (acc1) ref_alu(c1, a1, b1, m_res, m_zf, m_err);
        if (acc0 || acc1) begin
            m_full = 1'b1;
            m_id   = acc1;
            m_fav  = acc0;
        end else if (rsp_ready) begin
            m_full = 1'b0;
        end
        #1;
    endtask

    task automatic rand_op(output logic [31:0] a, output logic [31:0] b, output logic [2:0] c);
        logic [2:0] legal [5];
        legal = '{3'd0, 3'd1, 3'd2, 3'd6, 3'd7};
        case ($urandom % 3)
            0: begin a = $urandom; b = $urandom; end
            1: begin a = $urandom % 16; b = $urandom % 16; end
            default: begin a = $urandom; b = a; end
        endcase
`ifdef ALU_SHARE_CTL_CHECK_EN
        c = 3'($urandom % 8);
`else
        c = legal[$urandom % 5];
`endif
    endtask

    logic [31:0] held_res;
    logic        held_id, exp_id;

    initial begin
        model_reset();
        rst_n = 0; rsp_ready = 1;
        v0 = 1; a0 = 32'd1; b0 = 32'd2; c0 = 3'd2;
        v1 = 1; a1 = 32'd3; b1 = 32'd4; c1 = 3'd2;

        // reset with both valids high
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_res", rsp_res, 32'd0);
        check("rst_req0_ready", r0, 1'b0);
        check("rst_req1_ready", r1, 1'b0);
        rst_n = 1;
        step();
        check("first_winner_req0", dut_r0, 1'b1);
        v0 = 0; v1 = 0;
        step(); step();

        // single ADD on req0
        v0 = 1; a0 = 32'd10; b0 = 32'd15; c0 = 3'd2;
        step();
        v0 = 0;
        check("add_valid", rsp_valid, 1'b1);
        check("add_res", rsp_res, 32'd25);
        check("add_zf", rsp_zf, 1'b0);
        check("add_id", rsp_id, 1'b0);
        step();

        // req1 alone so req0 is favoured for the contention test
        v1 = 1; a1 = 32'd1; b1 = 32'd1; c1 = 3'd0;
        step();
        v1 = 0;
        step();

        // contention: OR on req0, SUB 7-7 on req1
        v0 = 1; a0 = 32'hF0F0F0F0; b0 = 32'h0F0F0F0F; c0 = 3'd1;
        v1 = 1; a1 = 32'd7; b1 = 32'd7; c1 = 3'd6;
        step();
        check("cont1_res", rsp_res, 32'hFFFFFFFF);
        check("cont1_zf", rsp_zf, 1'b0);
        check("cont1_id", rsp_id, 1'b0);
        v0 = 0;
        step();
        check("cont2_res", rsp_res, 32'd0);
        check("cont2_zf", rsp_zf, 1'b1);
        check("cont2_id", rsp_id, 1'b1);
        v1 = 0;

        // backpressure with both valid
        rsp_ready = 0;
        v0 = 1; a0 = 32'd100; b0 = 32'd1; c0 = 3'd6;
        v1 = 1; a1 = 32'd5;   b1 = 32'd6; c1 = 3'd2;
        step();
        held_res = rsp_res; held_id = rsp_id;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_req0_ready", dut_r0, 1'b0);
            check("bp_req1_ready", dut_r1, 1'b0);
            check("bp_res_stable", rsp_res, held_res);
            check("bp_id_stable", rsp_id, held_id);
        end
        rsp_ready = 1;
        step();
        check("bp_release_accept", dut_r0 | dut_r1, 1'b1);
        v0 = 0; v1 = 0;
        step(); step();

        // fairness with streaming SLT
        v0 = 1; a0 = 32'd3; b0 = 32'd8; c0 = 3'd7;
        v1 = 1; a1 = 32'd9; b1 = 32'd2; c1 = 3'd7;
        step();
        exp_id = rsp_id;
        for (int i = 0; i < 6; i++) begin
            step();
            exp_id = ~exp_id;
            check("slt_alt_id", rsp_id, exp_id);
            check("slt_res", rsp_res, exp_id ? 32'd0 : 32'd1);
            check("slt_zf", rsp_zf, exp_id);
        end
        v0 = 0; v1 = 0;
        step(); step();

`ifdef ALU_SHARE_CTL_CHECK_EN
        v0 = 1; a0 = 32'd1; b0 = 32'd1; c0 = 3'b100;
        step();
        v0 = 0;
        check("illegal_err", rsp_err, 1'b1);
        check("illegal_res", rsp_res, 32'd0);
        check("illegal_zf", rsp_zf, 1'b0);
        rsp_ready = 0;
        step();
        #2;
        rst_n = 0;
        #1;
        check("rst_full_clears", rsp_valid, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        rsp_ready = 1;
        step();
`endif

        // randomized traffic with random backpressure
        for (int n = 0; n < 400; n++) begin
            if (!v0 || acc0) begin
                v0 = ($urandom % 4) != 0;
                if (v0) rand_op(a0, b0, c0);
            end
            if (!v1 || acc1) begin
                v1 = ($urandom % 4) != 0;
                if (v1) rand_op(a1, b1, c1);
            end
            rsp_ready = ($urandom % 4) != 0;
            step();
        end
        v0 = 0; v1 = 0; rsp_ready = 1;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
